// File: rtl/uart_freq_tx.sv
// UART transmitter for the DDS frequency-word link: two 11-bit frames (start, byte-num, 8 data LSB first, stop), low byte first.
// Latency: tx falls 1 cycle after start is accepted. start is taken only in IDLE/DONE and ignored while busy. Optional UART_TX_GAP_EN inserts idle bits between frames.
module uart_freq_tx #(
    parameter int CLKS_PER_BIT = 521,
    parameter int GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] freq_word,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE_NUM,
        DATA,
        STOP,
`ifdef UART_TX_GAP_EN
        GAP,
`endif
        DONE
    } state_t;

    state_t      state, state_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next, clk_inc;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic        byte_sel, byte_sel_next;
    logic [15:0] word, word_next;
    logic [7:0]  byte_dat;
    logic        bit_end;
    logic        tx_next, busy_next, done_next;

`ifdef UART_TX_GAP_EN
    localparam int GW = $clog2(GAP_BITS + 1);
    logic [GW-1:0] gap_cnt, gap_cnt_next;
`endif

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign clk_inc = bit_end ? '0 : clk_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            byte_sel <= 1'b0;
            word     <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            clk_cnt  <= clk_cnt_next;
            bit_cnt  <= bit_cnt_next;
            byte_sel <= byte_sel_next;
            word     <= word_next;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

`ifdef UART_TX_GAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) gap_cnt <= '0;
        else        gap_cnt <= gap_cnt_next;
    end
`endif

    always_comb begin
        state_next    = state;
        clk_cnt_next  = clk_cnt;
        bit_cnt_next  = bit_cnt;
        byte_sel_next = byte_sel;
        word_next     = word;
`ifdef UART_TX_GAP_EN
        gap_cnt_next  = gap_cnt;
`endif
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    word_next     = freq_word;
                    byte_sel_next = 1'b0;
                    bit_cnt_next  = '0;
                    clk_cnt_next  = '0;
                    state_next    = START;
                end
            end
            START: begin
                clk_cnt_next = clk_inc;
                if (bit_end) state_next = BYTE_NUM;
            end
            BYTE_NUM: begin
                clk_cnt_next = clk_inc;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                clk_cnt_next = clk_inc;
                if (bit_end) begin
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                clk_cnt_next = clk_inc;
                if (bit_end) begin
                    if (!byte_sel) begin
                        byte_sel_next = 1'b1;
`ifdef UART_TX_GAP_EN
                        gap_cnt_next  = '0;
                        state_next    = GAP;
`else
                        state_next    = START;
`endif
                    end else begin
                        state_next = DONE;
                    end
                end
            end
`ifdef UART_TX_GAP_EN
            GAP: begin
                clk_cnt_next = clk_inc;
                if (bit_end) begin
                    gap_cnt_next = gap_cnt + GW'(1);
                    if (gap_cnt == GW'(GAP_BITS - 1)) state_next = START;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Outputs are registered from the next-state view so tx only moves on bit boundaries.
        byte_dat  = byte_sel_next ? word_next[15:8] : word_next[7:0];
        tx_next   = 1'b1;
        case (state_next)
            START:    tx_next = 1'b0;
            BYTE_NUM: tx_next = byte_sel_next;
            DATA:     tx_next = byte_dat[bit_cnt_next];
            default:  tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_uart_freq_tx.sv
// Directed bench for uart_freq_tx at 4 clocks per bit; bit sequences are checked against a frame model.
module tb_uart_freq_tx;

    localparam int CPB = 4;
    localparam int GB  = 2;
`ifdef UART_TX_GAP_EN
    localparam int GAP_T = GB;
`else
    localparam int GAP_T = 0;
`endif
    localparam int NB = 22 + GAP_T;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] freq_word;
    logic        tx, busy, done;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    uart_freq_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .freq_word(freq_word),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_frame(input logic [15:0] w);
        logic [31:0] e;
        logic [7:0]  b;
        int idx;
        e = '1;
        idx = 0;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? w[7:0] : w[15:8];
            e[idx] = 1'b0;          idx++;
            e[idx] = (k == 1);      idx++;
            for (int i = 0; i < 8; i++) begin
                e[idx] = b[i]; idx++;
            end
            e[idx] = 1'b1;          idx++;
            if (k == 0) idx += GAP_T;
        end
        return e;
    endfunction

    // Issue a one-cycle start; freq_word is scrambled right after acceptance.
    task automatic pulse(input logic [15:0] w);
        start = 1'b1;
        freq_word = w;
        tick();
        start = 1'b0;
        freq_word = ~w;
    endtask

    // Samples NB bit-times starting in the first START cycle; ends in the DONE cycle.
    task automatic capture(input int poke_cyc, input logic [15:0] poke_word,
                           output logic [31:0] bits, output int busy_cnt,
                           output int done_cnt, output int glitches);
        logic first;
        int c;
        bits = '1;
        busy_cnt = 0;
        done_cnt = 0;
        glitches = 0;
        for (int b = 0; b < NB; b++) begin
            first = tx;
            for (int k = 0; k < CPB; k++) begin
                c = b * CPB + k;
                if (c == poke_cyc) begin
                    start = 1'b1;
                    freq_word = poke_word;
                end else if (c == poke_cyc + 1) begin
                    start = 1'b0;
                end
                if (tx !== first) glitches++;
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) done_cnt++;
                tick();
            end
            bits[b] = first;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        freq_word = 16'h0;
        repeat (3) tick();
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
        end
        rst_n = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL reset_idle: %0d bad idle cycles, want 0", bad);
            end
        end
    endtask

    task automatic test_single_word();
        logic [31:0] bits;
        int bc, dc, gl;
        pulse(16'hA53C);
        capture(-10, 16'h0, bits, bc, dc, gl);
        tests++;
        if (bits !== exp_frame(16'hA53C) || gl != 0) begin
            fails++;
            $display("FAIL single_bits: got %b glitches %0d want %b glitches 0", bits, gl, exp_frame(16'hA53C));
        end
        tests++;
        if (bc != NB * CPB || dc != 0) begin
            fails++;
            $display("FAIL single_busy: busy %0d done %0d want busy %0d done 0", bc, dc, NB * CPB);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL single_done: done=%b busy=%b tx=%b want 1 0 1", done, busy, tx);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done_width: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] bits;
        int bc, dc, gl, extra;
        pulse(16'h1234);
        capture(20, 16'hFFFF, bits, bc, dc, gl);
        tests++;
        if (bits !== exp_frame(16'h1234) || gl != 0) begin
            fails++;
            $display("FAIL busy_start_bits: got %b want %b", bits, exp_frame(16'h1234));
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL busy_start_done: done=%b want 1", done);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL busy_start_quiet: %0d non-idle cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits;
        int bc, dc, gl, t1, t2;
        pulse(16'h00FF);
        capture(-10, 16'h0, bits, bc, dc, gl);
        t1 = cyc;
        tests++;
        if (bits !== exp_frame(16'h00FF) || done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: bits %b done %b want %b done 1", bits, done, exp_frame(16'h00FF));
        end
        pulse(16'hFF00);
        tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_restart: tx=%b busy=%b want 0 1", tx, busy);
        end
        capture(-10, 16'h0, bits, bc, dc, gl);
        t2 = cyc;
        tests++;
        if (bits !== exp_frame(16'hFF00) || bc != NB * CPB) begin
            fails++;
            $display("FAIL b2b_second: bits %b busy %0d want %b busy %0d", bits, bc, exp_frame(16'hFF00), NB * CPB);
        end
        tests++;
        if (done !== 1'b1 || (t2 - t1) != NB * CPB + 1) begin
            fails++;
            $display("FAIL b2b_spacing: done=%b spacing %0d want 1 spacing %0d", done, t2 - t1, NB * CPB + 1);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] bits;
        int bc, dc, gl;
        pulse(16'h5555);
        repeat (30) tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_busy_before: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midrst_abort: tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
        end
        rst_n = 1'b1;
        tick();
        pulse(16'h0001);
        capture(-10, 16'h0, bits, bc, dc, gl);
        tests++;
        if (bits !== exp_frame(16'h0001) || gl != 0 || done !== 1'b1) begin
            fails++;
            $display("FAIL midrst_resend: bits %b done %b want %b done 1", bits, done, exp_frame(16'h0001));
        end
        tick();
    endtask

`ifdef UART_TX_GAP_EN
    task automatic test_gap();
        logic [31:0] bits;
        int bc, dc, gl;
        pulse(16'hA53C);
        capture(-10, 16'h0, bits, bc, dc, gl);
        tests++;
        if (bits[11 +: GB] !== '1 || bits[11 + GB] !== 1'b0) begin
            fails++;
            $display("FAIL gap_idle: gap bits %b next %b want all 1 then 0", bits[11 +: GB], bits[11 + GB]);
        end
        tests++;
        if (bc != 96 || done !== 1'b1) begin
            fails++;
            $display("FAIL gap_busy: busy %0d done %b want 96 done 1", bc, done);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_GAP_EN
        test_gap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
